// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle SLL/SRL/SRA shifter, STEP bits per clock; rotate-right on mode 11 when SHIFT_ROTATE_EN is defined.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] work, nxt, rot;
  logic [SHAMT_W-1:0] count, s;
  logic [1:0] mode;
  logic zero_req;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    s = (32'(count) < STEP) ? count : SHAMT_W'(STEP);
`ifdef SHIFT_ROTATE_EN
    rot = (work >> s) | (work << (WIDTH - 32'(s)));
    zero_req = in_shamt == '0;
`else
    rot = work;
    zero_req = in_shamt == '0 || in_mode == 2'b11;
`endif
    nxt = mode == 2'b00 ? work << s :
          mode == 2'b01 ? work >> s :
          mode == 2'b10 ? $unsigned($signed(work) >>> s) : rot;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      count <= '0;
      mode <= 2'b00;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_data;
          mode <= in_mode;
          count <= zero_req ? '0 : in_shamt;
          if (zero_req) out_data <= in_data;
          state <= zero_req ? DONE : SHIFT;
        end
        SHIFT: begin
          work <= nxt;
          count <= count - s;
          if (32'(count) <= STEP) begin
            out_data <= nxt;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: model-based per-cycle checks plus directed literal vectors for iter_shift_unit.
module tb_iter_shift_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_shamt = 0;
  logic [1:0] in_mode = 0;
  int total = 0, bad = 0;
  logic m_busy, m_armed;
  int m_left;
  logic [31:0] m_res, m_data;
  iter_shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f_res(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] md);
    case (md)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return $unsigned($signed(d) >>> sh);
`ifdef SHIFT_ROTATE_EN
      default: return (d >> sh) | (d << (32 - int'(sh)));
`else
      default: return d;
`endif
    endcase
  endfunction
  function automatic int f_lat(input logic [4:0] sh, input logic [1:0] md);
`ifndef SHIFT_ROTATE_EN
    if (md == 2'b11) return 0;
`endif
    return (int'(sh) + 3) / 4;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_left <= 0; m_res <= 0; m_data <= 0; m_armed <= 0;
    end else if (!m_busy && in_valid) begin
      m_busy <= 1; m_armed <= 1;
      m_res <= f_res(in_data, in_shamt, in_mode);
      m_left <= f_lat(in_shamt, in_mode);
      if (f_lat(in_shamt, in_mode) == 0) m_data <= f_res(in_data, in_shamt, in_mode);
    end else if (m_busy && m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_data <= m_res;
    end else if (m_busy && out_ready) m_busy <= 0;
  end
  always @(posedge clk) begin
    #1;
    if (m_armed) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_busy && m_left == 0});
      chk("out_data", out_data, m_data);
    end
  end
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask
  task automatic release_out();
    @(negedge clk); out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask
  task automatic req(input string name, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] md,
                     input logic [31:0] exp, input int edges, input int hold);
    int n;
    @(negedge clk); in_valid = 1; in_data = d; in_shamt = sh; in_mode = md;
    @(posedge clk); #1;
    chk({name, "_accept_busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk); in_valid = 0; in_data = ~d; in_shamt = ~sh; in_mode = ~md;
    wait_valid(n);
    chk({name, "_edges"}, n, edges);
    chk({name, "_data"}, out_data, exp);
    repeat (hold) @(negedge clk);
    chk({name, "_held"}, out_data, exp);
    release_out();
  endtask
  initial begin
    int n;
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1;
    req("sll2", 32'h00000002, 5'd2, 2'b00, 32'h00000008, 1, 0);
    req("sll3", 32'h0000000A, 5'd3, 2'b00, 32'h00000050, 1, 0);
    req("sra4", 32'hF0F0F0F0, 5'd4, 2'b10, 32'hFF0F0F0F, 1, 0);
    req("srl31", 32'hF0F0F0F0, 5'd31, 2'b01, 32'h00000001, 8, 0);
    req("sra31", 32'h80000000, 5'd31, 2'b10, 32'hFFFFFFFF, 8, 0);
    req("sll0", 32'hDEADBEEF, 5'd0, 2'b00, 32'hDEADBEEF, 0, 0);
    req("bp", 32'h00000001, 5'd5, 2'b00, 32'h00000020, 2, 5);
`ifdef SHIFT_ROTATE_EN
    req("rot1", 32'h00000001, 5'd1, 2'b11, 32'h80000000, 1, 0);
    req("rot9", 32'h00000F01, 5'd9, 2'b11, 32'h80800007, 3, 0);
`else
    req("mode3", 32'h00000001, 5'd1, 2'b11, 32'h00000001, 0, 0);
    req("mode3b", 32'h12345678, 5'd17, 2'b11, 32'h12345678, 0, 0);
`endif
    @(negedge clk); in_valid = 1; in_data = 32'h80000000; in_shamt = 5'd8; in_mode = 2'b01;
    @(negedge clk); in_valid = 0;
    wait_valid(n);
    chk("ovl_first", out_data, 32'h00800000);
    @(negedge clk); in_valid = 1; in_data = 32'h00000003; in_shamt = 5'd1; in_mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("ovl_wait_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1;
    @(posedge clk); #1;
    chk("ovl_not_taken", {31'b0, busy}, 32'd0);
    @(negedge clk); out_ready = 0;
    @(posedge clk); #1;
    chk("ovl_taken", {31'b0, busy}, 32'd1);
    @(negedge clk); in_valid = 0;
    wait_valid(n);
    chk("ovl_edges", n, 1);
    chk("ovl_data", out_data, 32'h00000006);
    release_out();
    @(negedge clk); in_valid = 1; in_data = 32'hFFFF0000; in_shamt = 5'd20; in_mode = 2'b01;
    @(posedge clk); @(negedge clk); in_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    chk("rmid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rmid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_out_data", out_data, 32'h0);
    @(negedge clk); rst_n = 1;
    req("post_rst", 32'hFFFF0000, 5'd20, 2'b01, 32'h00000FFF, 5, 0);
    req("sra_pos", 32'h7F000000, 5'd7, 2'b10, 32'h00FE0000, 2, 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
